// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin front end that lets N_REQ clients share one
// 16x16 unsigned multiplier through a two-entry (S1 operand / S2 product)
// pipeline. Responses come back on one channel tagged with the requester id.
// DADDA_16x16_42 is the shared combinational multiplier, kept in this file.

module DADDA_16x16_42 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] out
);
    // Vector 4:2 compressor built from two carry-save stages.
    // The result is {carry_row, sum_row}, which sums to w+x+y+z mod 2^32.
    function automatic logic [63:0] comp42(input logic [31:0] w, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] z);
        logic [31:0] s1;
        logic [31:0] c1;
        logic [31:0] s2;
        logic [31:0] c2;
        s1 = w ^ x ^ y;
        c1 = ((w & x) | (w & y) | (x & y)) << 1;
        s2 = s1 ^ c1 ^ z;
        c2 = ((s1 & c1) | (s1 & z) | (c1 & z)) << 1;
        return {c2, s2};
    endfunction

    logic [31:0] pp [16];
    logic [31:0] l1 [8];
    logic [31:0] l2 [4];
    logic [31:0] l3 [2];

    // One shifted partial product per bit of b.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pp
        assign pp[gi] = b[gi] ? ({16'h0000, a} << gi) : 32'h0000_0000;
    end

    // Reduction tree: 16 -> 8 -> 4 -> 2 rows.
    for (genvar gi = 0; gi < 4; gi++) begin : g_l1
        assign {l1[2*gi+1], l1[2*gi]} = comp42(pp[4*gi], pp[4*gi+1], pp[4*gi+2], pp[4*gi+3]);
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_l2
        assign {l2[2*gi+1], l2[2*gi]} = comp42(l1[4*gi], l1[4*gi+1], l1[4*gi+2], l1[4*gi+3]);
    end
    assign {l3[1], l3[0]} = comp42(l2[0], l2[1], l2[2], l2[3]);

    // Final carry-propagate add of the last two rows.
    assign out = l3[0] + l3[1];
endmodule

module mul_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*16-1:0]   req_a,
    input  logic [N_REQ*16-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    input  logic                  rsp_ready
);
    localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic            s1_valid_q, s1_valid_d;
    logic [15:0]     s1_a_q, s1_a_d;
    logic [15:0]     s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic [31:0]     s2_data_q, s2_data_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic            s2_load;
    logic            s1_move;
    logic            s1_accept;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   scan_idx;
    logic            handshake;
    logic [15:0]     win_a;
    logic [15:0]     win_b;
    logic [31:0]     mul_out;

    assign s2_load   = !s2_valid_q || rsp_ready;
    assign s1_move   = s1_valid_q && s2_load;
    assign s1_accept = !s1_valid_q || s1_move;

    // Winner: first valid requester scanning upward from ptr, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (!win_found && req_valid[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    assign handshake = win_found && s1_accept;
    assign win_a     = req_a[32'(win_id)*16 +: 16];
    assign win_b     = req_b[32'(win_id)*16 +: 16];

    // Grant is one-hot on the winner, forced low while reset is held.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = reset_n && handshake && (win_id == ID_W'(gi));
    end

    DADDA_16x16_42 u_mul (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .out (mul_out)
    );

    // Next state for both pipeline stages and the priority pointer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        ptr_d      = ptr_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_data_d  = s2_data_q;
        if (handshake) begin
            s1_valid_d = 1'b1;
            s1_a_d     = win_a;
            s1_b_d     = win_b;
            s1_id_d    = win_id;
            ptr_d      = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_id_d   = s1_id_q;
                s2_data_d = mul_out;
            end
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            ptr_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            ptr_q      <= ptr_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_data_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: vector table through a single
// requester, random products, then hand-written multi-cycle sequences.
module tb_mul_share_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    mul_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vt [6];
    logic [31:0] prod [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic to_mid();
        @(negedge clock);
    endtask

    task automatic do_reset();
        req_valid = 4'h0;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    // Requesters share fixed operands; products computed by the bench.
    task automatic load_fixed_ops();
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(i*257 + 3);
            req_b[i*16 +: 16] = 16'(i*1000 + 11);
            prod[i] = 32'(req_a[i*16 +: 16]) * 32'(req_b[i*16 +: 16]);
        end
    endtask

    // One isolated transaction from an empty pipeline, rsp_ready high.
    task automatic run_one(input string name, input int id, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] p);
        req_valid = 4'(1 << id);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        rsp_ready = 1'b1;
        to_mid();
        chk({name, " grant"}, 32'(req_ready), 32'(1 << id));
        chk({name, " rsp_idle"}, 32'(rsp_valid), 32'd0);
        next_cycle();
        req_valid = 4'h0;
        to_mid();
        chk({name, " grant_once"}, 32'(req_ready), 32'd0);
        chk({name, " rsp_not_yet"}, 32'(rsp_valid), 32'd0);
        next_cycle();
        to_mid();
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " rsp_id"}, 32'(rsp_id), 32'(id));
        chk({name, " rsp_data"}, rsp_data, p);
        next_cycle();
    endtask

    initial begin
        vt[0] = '{2, 16'd3,    16'd5,    32'd15};
        vt[1] = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vt[2] = '{1, 16'h0000, 16'h1234, 32'h0000_0000};
        vt[3] = '{3, 16'h8000, 16'h0002, 32'h0001_0000};
        vt[4] = '{2, 16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vt[5] = '{0, 16'h1234, 16'h5678, 32'h0626_0060};

        // Outputs must be zero while reset is held, even with requests pending.
        req_valid = 4'hF;
        #12;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        req_valid = 4'h0;
        #1 reset_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 6; i++) begin
            run_one($sformatf("vec%0d", i), vt[i].id, vt[i].a, vt[i].b, vt[i].p);
        end

        for (int i = 0; i < 100; i++) begin
            int          rid;
            logic [15:0] ra;
            logic [15:0] rb;
            rid = int'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            run_one($sformatf("rnd%0d", i), rid, ra, rb, 32'(ra) * 32'(rb));
        end

        // Round robin: all valid for 8 cycles, responses two cycles behind.
        next_cycle();
        do_reset();
        load_fixed_ops();
        rsp_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            to_mid();
            if (c < 8) chk($sformatf("rr grant c%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            else       chk($sformatf("rr grant c%0d", c), 32'(req_ready), 32'd0);
            if (c >= 2 && c < 10) begin
                chk($sformatf("rr rsp_valid c%0d", c), 32'(rsp_valid), 32'd1);
                chk($sformatf("rr rsp_id c%0d", c), 32'(rsp_id), 32'((c - 2) % 4));
                chk($sformatf("rr rsp_data c%0d", c), rsp_data, prod[(c - 2) % 4]);
            end else begin
                chk($sformatf("rr rsp_valid c%0d", c), 32'(rsp_valid), 32'd0);
            end
            next_cycle();
        end

        // Backpressure: two handshakes fill the pipe, then everything stalls.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        to_mid();
        chk("bp grant0", 32'(req_ready), 32'h1);
        next_cycle();
        to_mid();
        chk("bp grant1", 32'(req_ready), 32'h2);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            to_mid();
            chk($sformatf("bp stall ready c%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp stall valid c%0d", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp stall id c%0d", c), 32'(rsp_id), 32'd0);
            chk($sformatf("bp stall data c%0d", c), rsp_data, prod[0]);
            next_cycle();
        end
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        to_mid();
        chk("bp drain0 id", 32'(rsp_id), 32'd0);
        chk("bp drain0 data", rsp_data, prod[0]);
        next_cycle();
        to_mid();
        chk("bp drain1 valid", 32'(rsp_valid), 32'd1);
        chk("bp drain1 id", 32'(rsp_id), 32'd1);
        chk("bp drain1 data", rsp_data, prod[1]);
        next_cycle();
        to_mid();
        chk("bp drained", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Reset mid-operation with both stages full (ptr is at 2 here).
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        to_mid();
        chk("rst fill grant2", 32'(req_ready), 32'h4);
        next_cycle();
        to_mid();
        chk("rst fill grant3", 32'(req_ready), 32'h8);
        next_cycle();
        to_mid();
        chk("rst full valid", 32'(rsp_valid), 32'd1);
        chk("rst full id", 32'(rsp_id), 32'd2);
        #1 reset_n = 1'b0;
        #1;
        chk("rst async rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst async req_ready", 32'(req_ready), 32'd0);
        chk("rst async rsp_data", rsp_data, 32'd0);
        req_valid = 4'h0;
        #2 reset_n = 1'b1;
        next_cycle();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        to_mid();
        chk("rst after grant", 32'(req_ready), 32'h1);
        chk("rst no stale", 32'(rsp_valid), 32'd0);
        next_cycle();
        req_valid = 4'h0;
        to_mid();
        chk("rst no stale2", 32'(rsp_valid), 32'd0);
        next_cycle();
        to_mid();
        chk("rst new rsp id", 32'(rsp_id), 32'd0);
        chk("rst new rsp data", rsp_data, prod[0]);
        next_cycle();
        next_cycle();

        // Late arrival: requester 1 waits at ptr=1 while 3 joins; 1 wins.
        do_reset();
        rsp_ready = 1'b0;
        req_a[15:0] = 16'd7;
        req_b[15:0] = 16'd9;
        req_valid = 4'h1;
        to_mid();
        chk("late r0 first", 32'(req_ready), 32'h1);
        next_cycle();
        req_a[15:0] = 16'd11;
        req_b[15:0] = 16'd13;
        to_mid();
        chk("late r0 second", 32'(req_ready), 32'h1);
        next_cycle();
        req_a[31:16] = 16'h0100;
        req_b[31:16] = 16'h0100;
        req_a[63:48] = 16'hFFFF;
        req_b[63:48] = 16'h0002;
        req_valid = 4'h2;
        to_mid();
        chk("late full r1", 32'(req_ready), 32'd0);
        next_cycle();
        req_valid = 4'hA;
        to_mid();
        chk("late full r1r3", 32'(req_ready), 32'd0);
        next_cycle();
        rsp_ready = 1'b1;
        to_mid();
        chk("late grant r1", 32'(req_ready), 32'h2);
        chk("late rsp0 data", rsp_data, 32'd63);
        next_cycle();
        req_valid = 4'h8;
        to_mid();
        chk("late grant r3", 32'(req_ready), 32'h8);
        chk("late rsp1 data", rsp_data, 32'd143);
        next_cycle();
        req_valid = 4'h0;
        to_mid();
        chk("late rsp2 id", 32'(rsp_id), 32'd1);
        chk("late rsp2 data", rsp_data, 32'h0001_0000);
        next_cycle();
        to_mid();
        chk("late rsp3 id", 32'(rsp_id), 32'd3);
        chk("late rsp3 data", rsp_data, 32'h0001_FFFE);
        next_cycle();
        to_mid();
        chk("late drained", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
